// File: rtl/eflags_cond_unit_pkg.sv
// EFLAGS / condition-code shared definitions.
// Flag bit positions, reset value and the x86 cccc encoding.
package eflags_cond_unit_pkg;

  localparam int EFLAGS_CF = 0;
  localparam int EFLAGS_RSV1 = 1;
  localparam int EFLAGS_PF = 2;
  localparam int EFLAGS_AF = 4;
  localparam int EFLAGS_ZF = 6;
  localparam int EFLAGS_SF = 7;
  localparam int EFLAGS_OF = 11;

  localparam logic [63:0] EFLAGS_RESET = 64'h2;

  localparam int PEND_MAX_DEF = 3;
  localparam int PEND_W_DEF = $clog2(PEND_MAX_DEF + 1);

  typedef enum logic [3:0] {
    COND_O  = 4'h0,
    COND_NO = 4'h1,
    COND_B  = 4'h2,
    COND_AE = 4'h3,
    COND_E  = 4'h4,
    COND_NE = 4'h5,
    COND_BE = 4'h6,
    COND_A  = 4'h7,
    COND_S  = 4'h8,
    COND_NS = 4'h9,
    COND_P  = 4'hA,
    COND_NP = 4'hB,
    COND_L  = 4'hC,
    COND_GE = 4'hD,
    COND_LE = 4'hE,
    COND_G  = 4'hF
  } cond_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } cond_state_t;

endpackage

// File: rtl/eflags_cond_unit_if.sv
// Flag update, popf write and condition query/response bundle.
// master drives requests and updates, slave is the flag unit.
interface eflags_cond_unit_if
  import eflags_cond_unit_pkg::*;
#(
  parameter int REG_W = 64,
  parameter int PW = PEND_W_DEF
);

  logic             issue_flag_op;
  logic             issue_ready;
  logic             upd_valid;
  logic [REG_W-1:0] upd_eflags;
  logic             wr_valid;
  logic [REG_W-1:0] wr_data;
  logic             cond_valid;
  logic [3:0]       cond_code;
  logic             cond_ready;
  logic             res_valid;
  logic             res_taken;
  logic             res_ready;
  logic [REG_W-1:0] eflags;
  logic [PW-1:0]    pending;
  logic             err;

  modport master (
    output issue_flag_op, upd_valid, upd_eflags,
    output wr_valid, wr_data,
    output cond_valid, cond_code, res_ready,
    input  issue_ready, cond_ready,
    input  res_valid, res_taken,
    input  eflags, pending, err
  );

  modport slave (
    input  issue_flag_op, upd_valid, upd_eflags,
    input  wr_valid, wr_data,
    input  cond_valid, cond_code, res_ready,
    output issue_ready, cond_ready,
    output res_valid, res_taken,
    output eflags, pending, err
  );

endinterface

// File: rtl/eflags_cond_unit_cond_eval.sv
// x86 condition evaluator for Jcc/SETcc/CMOVcc.
// Even codes test a predicate, odd codes invert it.
module cond_eval
  import eflags_cond_unit_pkg::*;
#(
  parameter int REG_W = 64
) (
  input  logic [3:0]       cond_code,
  input  logic [REG_W-1:0] flags,
  output logic             taken
);

  logic cf, pf, zf, sf, of_f;
  logic base;
  logic unused_flags;

  assign cf   = flags[EFLAGS_CF];
  assign pf   = flags[EFLAGS_PF];
  assign zf   = flags[EFLAGS_ZF];
  assign sf   = flags[EFLAGS_SF];
  assign of_f = flags[EFLAGS_OF];

  assign unused_flags = ^{flags[REG_W-1:12], flags[10:8],
                          flags[5:3], flags[1]};

  // Predicate for the even code of each pair
  always_comb begin
    base = 1'b0;
    unique case (cond_code[3:1])
      3'd0: base = of_f;
      3'd1: base = cf;
      3'd2: base = zf;
      3'd3: base = cf | zf;
      3'd4: base = sf;
      3'd5: base = pf;
      3'd6: base = sf ^ of_f;
      3'd7: base = zf | (sf ^ of_f);
      default: base = 1'b0;
    endcase
  end

  assign taken = base ^ cond_code[0];

endmodule

// File: rtl/eflags_cond_unit.sv
// Architectural EFLAGS register with in-flight op tracking.
// Condition queries wait for every older flag op to land.
module eflags_cond_unit
  import eflags_cond_unit_pkg::*;
#(
  parameter int REG_W = 64,
  parameter int PEND_MAX = 3
) (
  input logic clk,
  input logic rst,
  eflags_cond_unit_if.slave bus
);

  localparam int PW = $clog2(PEND_MAX + 1);
  localparam logic [PW-1:0] PMAX = PW'(PEND_MAX);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [REG_W-1:0] RSV = REG_W'(EFLAGS_RESET);

  logic [REG_W-1:0] eflags_q, eflags_n;
  logic [PW-1:0]    pend_q, pend_n;
  logic [PW-1:0]    wait_q, wait_n;
  logic [PW-1:0]    wait_acc;
  logic [3:0]       code_q, code_n;
  logic             taken_q, taken_n;
  logic             err_q, err_n;
  cond_state_t      state_q, state_n;

  logic             full, empty, issue_ok;
  logic [REG_W-1:0] upd_flags, eval_flags;
  logic [3:0]       eval_code;
  logic             eval_taken;

  assign full      = (pend_q == PMAX);
  assign empty     = (pend_q == '0);
  assign issue_ok  = bus.issue_flag_op & ~full;
  assign upd_flags = bus.upd_eflags | RSV;

  // Counter, register write and sticky error next-state
  always_comb begin
    pend_n   = pend_q;
    eflags_n = eflags_q;
    err_n    = err_q;
    if (bus.issue_flag_op & full)
      err_n = 1'b1;
    if (bus.upd_valid & empty & ~issue_ok)
      err_n = 1'b1;
    if (bus.wr_valid & (bus.upd_valid | ~empty))
      err_n = 1'b1;
    unique case ({issue_ok, bus.upd_valid})
      2'b10: pend_n = pend_q + ONE;
      2'b01: if (!empty) pend_n = pend_q - ONE;
      default: pend_n = pend_q;
    endcase
    if (bus.upd_valid)
      eflags_n = upd_flags;
    else if (bus.wr_valid & empty)
      eflags_n = bus.wr_data | RSV;
  end

  assign eval_flags = bus.upd_valid ? upd_flags : eflags_q;
  assign eval_code  = (state_q == S_WAIT) ? code_q
                                          : bus.cond_code;

  cond_eval #(.REG_W(REG_W)) u_eval (
    .cond_code (eval_code),
    .flags     (eval_flags),
    .taken     (eval_taken)
  );

  // Same-cycle issue is younger than the query, so not counted
  assign wait_acc = (bus.upd_valid & ~empty) ? pend_q - ONE
                                             : pend_q;

  // Query FSM next-state
  always_comb begin
    state_n = state_q;
    wait_n  = wait_q;
    code_n  = code_q;
    taken_n = taken_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cond_valid) begin
          if (wait_acc == '0) begin
            taken_n = eval_taken;
            state_n = S_RESP;
          end else begin
            wait_n  = wait_acc;
            code_n  = bus.cond_code;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.upd_valid) begin
          wait_n = wait_q - ONE;
          if (wait_q == ONE) begin
            taken_n = eval_taken;
            state_n = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bus.res_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Architectural state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      eflags_q <= RSV;
      pend_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      eflags_q <= eflags_n;
      pend_q   <= pend_n;
      err_q    <= err_n;
    end
  end

  // Query FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      code_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_n;
      wait_q  <= wait_n;
      code_q  <= code_n;
      taken_q <= taken_n;
    end
  end

  assign bus.eflags      = eflags_q;
  assign bus.pending     = pend_q;
  assign bus.err         = err_q;
  assign bus.issue_ready = ~full;
  assign bus.cond_ready  = (state_q == S_IDLE);
  assign bus.res_valid   = (state_q == S_RESP);
  assign bus.res_taken   = taken_q;

endmodule

// File: tb/tb_eflags_cond_unit.sv
// Directed bench for eflags_cond_unit.
// Expected values are hand-computed constants.
module tb_eflags_cond_unit;

  logic clk;
  logic rst;
  int ncmp;
  int nerr;

  eflags_cond_unit_if #(.REG_W(64), .PW(2)) bus ();

  eflags_cond_unit #(.REG_W(64), .PEND_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic query(input int c, input logic exp);
    bus.cond_valid = 1'b1;
    bus.cond_code = 4'(c);
    tick();
    bus.cond_valid = 1'b0;
    check($sformatf("q%0h_valid", c), 64'(bus.res_valid), 64'd1);
    check($sformatf("q%0h_taken", c), 64'(bus.res_taken), 64'(exp));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic table_run(input logic [63:0] wv,
                           input logic [15:0] exp_tbl);
    logic [15:0] t;
    t = exp_tbl;
    bus.wr_valid = 1'b1;
    bus.wr_data = wv;
    tick();
    bus.wr_valid = 1'b0;
    check("tbl_wr", bus.eflags, wv | 64'h2);
    for (int i = 0; i < 16; i++)
      query(i, t[i]);
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    rst = 1'b1;
    bus.issue_flag_op = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_eflags = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.cond_valid = 1'b0;
    bus.cond_code = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_eflags", bus.eflags, 64'h2);
    check("rst_pending", 64'(bus.pending), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_taken", 64'(bus.res_taken), 64'd0);
    check("rst_cond_ready", 64'(bus.cond_ready), 64'd1);
    check("rst_issue_ready", 64'(bus.issue_ready), 64'd1);

    // Query E right after reset
    bus.cond_valid = 1'b1;
    bus.cond_code = 4'h4;
    tick();
    bus.cond_valid = 1'b0;
    check("e_valid", 64'(bus.res_valid), 64'd1);
    check("e_taken", 64'(bus.res_taken), 64'd0);
    check("e_eflags", bus.eflags, 64'h2);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("e_idle", 64'(bus.cond_ready), 64'd1);
    check("e_drop", 64'(bus.res_valid), 64'd0);

    // Two ops in flight, query BE waits for both
    bus.issue_flag_op = 1'b1;
    tick();
    tick();
    bus.issue_flag_op = 1'b0;
    check("be_pend2", 64'(bus.pending), 64'd2);
    bus.cond_valid = 1'b1;
    bus.cond_code = 4'h6;
    tick();
    bus.cond_valid = 1'b0;
    check("be_wait_valid", 64'(bus.res_valid), 64'd0);
    check("be_wait_ready", 64'(bus.cond_ready), 64'd0);
    bus.upd_valid = 1'b1;
    bus.upd_eflags = 64'h1;
    tick();
    check("be_upd1_valid", 64'(bus.res_valid), 64'd0);
    check("be_upd1_pend", 64'(bus.pending), 64'd1);
    check("be_upd1_eflags", bus.eflags, 64'h3);
    bus.upd_eflags = 64'h40;
    tick();
    bus.upd_valid = 1'b0;
    check("be_valid", 64'(bus.res_valid), 64'd1);
    check("be_taken", 64'(bus.res_taken), 64'd1);
    check("be_eflags", bus.eflags, 64'h42);
    check("be_pend0", 64'(bus.pending), 64'd0);

    // Back-pressure: hold response 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 64'(bus.res_valid), 64'd1);
      check("hold_taken", 64'(bus.res_taken), 64'd1);
      check("hold_cready", 64'(bus.cond_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("hold_idle", 64'(bus.cond_ready), 64'd1);
    check("hold_drop", 64'(bus.res_valid), 64'd0);

    // Forwarded L with same-cycle update and issue
    bus.issue_flag_op = 1'b1;
    tick();
    check("fw_pend1", 64'(bus.pending), 64'd1);
    bus.cond_valid = 1'b1;
    bus.cond_code = 4'hC;
    bus.upd_valid = 1'b1;
    bus.upd_eflags = 64'h880;
    tick();
    bus.cond_valid = 1'b0;
    bus.upd_valid = 1'b0;
    bus.issue_flag_op = 1'b0;
    check("fw_valid", 64'(bus.res_valid), 64'd1);
    check("fw_taken", 64'(bus.res_taken), 64'd0);
    check("fw_pend", 64'(bus.pending), 64'd1);
    check("fw_eflags", bus.eflags, 64'h882);
    check("fw_err", 64'(bus.err), 64'd0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // popf while an op is in flight is dropped
    bus.wr_valid = 1'b1;
    bus.wr_data = 64'hFFF;
    tick();
    bus.wr_valid = 1'b0;
    check("wrp_eflags", bus.eflags, 64'h882);
    check("wrp_err", 64'(bus.err), 64'd1);

    // Update with nothing pending
    do_reset();
    check("rst2_err", 64'(bus.err), 64'd0);
    bus.upd_valid = 1'b1;
    bus.upd_eflags = 64'h80;
    tick();
    bus.upd_valid = 1'b0;
    check("upd0_eflags", bus.eflags, 64'h82);
    check("upd0_pend", 64'(bus.pending), 64'd0);
    check("upd0_err", 64'(bus.err), 64'd1);

    // Issue beyond PEND_MAX
    do_reset();
    bus.issue_flag_op = 1'b1;
    tick();
    tick();
    tick();
    bus.issue_flag_op = 1'b0;
    check("full_pend", 64'(bus.pending), 64'd3);
    check("full_iready", 64'(bus.issue_ready), 64'd0);
    check("full_err0", 64'(bus.err), 64'd0);
    bus.issue_flag_op = 1'b1;
    tick();
    bus.issue_flag_op = 1'b0;
    check("ovf_pend", 64'(bus.pending), 64'd3);
    check("ovf_err", 64'(bus.err), 64'd1);

    // Reset while a query waits
    do_reset();
    bus.issue_flag_op = 1'b1;
    tick();
    bus.issue_flag_op = 1'b0;
    bus.cond_valid = 1'b1;
    bus.cond_code = 4'h0;
    tick();
    bus.cond_valid = 1'b0;
    check("wrst_inwait", 64'(bus.cond_ready), 64'd0);
    do_reset();
    check("wrst_cready", 64'(bus.cond_ready), 64'd1);
    check("wrst_rvalid", 64'(bus.res_valid), 64'd0);
    check("wrst_pend", 64'(bus.pending), 64'd0);
    check("wrst_eflags", bus.eflags, 64'h2);
    check("wrst_err0", 64'(bus.err), 64'd0);
    bus.upd_valid = 1'b1;
    bus.upd_eflags = 64'h1;
    tick();
    bus.upd_valid = 1'b0;
    check("wrst_err1", 64'(bus.err), 64'd1);
    check("wrst_cready2", 64'(bus.cond_ready), 64'd1);

    // Full condition tables via popf-loaded flags
    do_reset();
    table_run(64'h41, 16'h6A56);
    table_run(64'h884, 16'hA5A9);
    table_run(64'h80, 16'h59AA);
    check("tbl_err", 64'(bus.err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/eflags_cond_unit.md
Name: eflags_cond_unit

Overview:
- Holds the architectural EFLAGS register and is the consumer side of the ALU flag interface: it absorbs each eflags/eflags_update result, and supplies eflags_as_src back to the ALU.
- Evaluates x86 condition codes for Jcc/SETcc/CMOVcc through a valid/ready request/response handshake.
- Tracks in-flight flag-producing ALU ops, so that a condition query always sees the flags of every op issued before it.

Parameters:
- REG_W, 64, EFLAGS register width (matches reg_t).
- PEND_MAX, 3, max flag-producing ops in flight; the counter width is $clog2(PEND_MAX+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- issue_flag_op  in  1  a flag-producing op is dispatched to the ALU this cycle
- issue_ready  out  1  pending count < PEND_MAX; issue_flag_op is legal only when this is 1
- upd_valid  in  1  ALU eflags_update for a completing op
- upd_eflags  in  REG_W  ALU eflags output
- wr_valid  in  1  explicit full write (popf)
- wr_data  in  REG_W  popf value
- cond_valid  in  1  condition query valid
- cond_code  in  4  x86 cccc field
- cond_ready  out  1  query accepted when cond_valid & cond_ready
- res_valid  out  1  result valid; held until res_ready
- res_taken  out  1  condition outcome
- res_ready  in  1  result consumed
- eflags  out  REG_W  architectural EFLAGS; drives the ALU eflags_as_src
- pending  out  clog2  in-flight flag-op count
- err  out  1  sticky protocol error

Behaviour:
- Reset values (any cycle, including mid-query):
  - eflags = 64'h2
  - pending = 0, err = 0
  - FSM = IDLE; res_valid = 0, res_taken = 0
  - cond_ready = 1, issue_ready = 1
- Write rule: every write to eflags forces bit 1 to 1. Flag bits are CF 0, PF 2, AF 4, ZF 6, SF 7, OF 11.
- Pending counter:
  - issue only: +1. upd only: -1. Both in the same cycle: unchanged.
  - upd_valid with pending == 0 and no same-cycle issue: eflags is still written, the counter stays 0, err is set.
  - issue_flag_op with pending == PEND_MAX: ignored, err is set.
- Write priority: upd_valid has priority over wr_valid.
  - wr_valid is honoured only when pending == 0 and upd_valid == 0; otherwise it is dropped and err is set.
  - All eflags writes take effect at the next clk edge.
- Condition mapping (cond_code):
  - 0 OF; 1 !OF; 2 CF; 3 !CF; 4 ZF; 5 !ZF; 6 CF|ZF; 7 !(CF|ZF)
  - 8 SF; 9 !SF; A PF; B !PF; C SF^OF; D !(SF^OF); E ZF|(SF^OF); F !(ZF|(SF^OF))
- FSM IDLE / WAIT / RESP; cond_ready = (state == IDLE).
  - IDLE, on accept: wait_cnt = pending - (upd_valid ? 1 : 0), floored at 0. The same-cycle issue is excluded because it is younger than the query.
    - If upd_valid and wait_cnt == 0: evaluate on upd_eflags, go to RESP.
    - Else if wait_cnt == 0: evaluate on eflags, go to RESP.
    - Else: latch cond_code, go to WAIT.
  - WAIT: each upd_valid decrements wait_cnt. On the update that makes it 0, evaluate on that cycle's upd_eflags (forwarded) and go to RESP. Issues in WAIT do not touch wait_cnt.
  - RESP: res_valid = 1 and res_taken is stable. On res_ready, go to IDLE. A new query can be accepted the cycle after.
- Latency: 1 cycle minimum from accept to res_valid. Throughput: 1 query per 2 cycles.
- wr_valid during WAIT is dropped with err set, because pending > 0 in WAIT.

Decomposition:
- Shared package (alongside common_params.h):
  - cond_t enum (COND_O … COND_G, 4 bits)
  - EFLAGS_RESET = 64'h2
  - reuse the existing `EFLAGS_CF/PF/AF/ZF/SF/OF defines
- One combinational sub-module, cond_eval (inputs cond_code and flags REG_W; output taken). The bench reuses it as the reference model.
- The top level holds the register, pending counter, wait_cnt and FSM.

Test Plan:
- Reset then query cond 4 (E): res_valid 1 cycle after accept, res_taken = 0, eflags = 64'h2.
- Issue 2 flag ops, then query cond 6 (BE); upd #1 = 64'h1 (CF), upd #2 = 64'h40 (ZF): res_valid in the cycle after upd #2, res_taken = 1, eflags = 64'h42.
- Query cond C (L) accepted in the same cycle as a single upd = 64'h880 (SF|OF) with pending = 1: forwarded, res_taken = 0; a same-cycle issue_flag_op leaves pending = 1.
- Hold res_ready = 0 for 5 cycles: res_valid and res_taken stable, cond_ready = 0, then IDLE one cycle after res_ready.
- Protocol errors:
  - wr_valid while pending = 1 → eflags unchanged, err = 1.
  - upd_valid with pending = 0 → eflags written, err = 1.
  - issue_flag_op at pending = 3 → issue_ready = 0, err = 1.
- Assert rst while in WAIT → next cycle state IDLE, res_valid = 0, pending = 0, eflags = 64'h2. A later upd with no issue sets err.
